// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch : sequences a program out of a synchronous instruction BRAM into the CLP
// Rev 1.0 | optional watchdog enabled by defining INSTR_WATCHDOG_EN
// ============================================================================
`default_nettype none

module instruction_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int WDT_LIMIT  = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] instr_num,
    output logic [ADDR_WIDTH-1:0] inst_mem_addr,
    input  logic [63:0]           inst_mem_dout,
    output logic [63:0]           instruction,
    output logic                  CLP_enable,
    input  logic                  CLP_done,
    output logic                  busy,
    output logic                  program_done,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        ISSUE     = 3'd3,
        EXEC      = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] last_pc;
    logic                  wdt_expired;

    // pc only changes on the transition into FETCH, so the BRAM sees a stable
    // address for the whole FETCH cycle and its data lands during WAIT_DATA.
    assign inst_mem_addr = pc;
    assign busy          = (state != IDLE);
    assign CLP_enable    = (state == ISSUE);
    assign program_done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            last_pc     <= '0;
            instruction <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (instr_num != '0) begin
                            last_pc <= instr_num - 1'b1;
                            pc      <= '0;
                            state   <= FETCH;
                        end else begin
                            state   <= DONE;
                        end
                    end
                end
                FETCH: begin
                    state <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    instruction <= inst_mem_dout;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    state <= EXEC;
                end
                EXEC: begin
                    // Completion wins over a watchdog expiry on the same cycle.
                    if (CLP_done) begin
                        if (pc == last_pc) begin
                            state <= DONE;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= FETCH;
                        end
                    end else if (wdt_expired) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_WATCHDOG_EN
    localparam logic [15:0] WDT_LAST = 16'(WDT_LIMIT - 1);

    logic [15:0] wdt_cnt;
    logic        wdt_err;

    assign wdt_expired = (wdt_cnt == WDT_LAST);
    assign timeout_err = wdt_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt <= '0;
            wdt_err <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wdt_cnt <= '0;
            end else if (state == EXEC) begin
                wdt_cnt <= wdt_cnt + 16'd1;
            end
            if ((state == EXEC) && !CLP_done && wdt_expired) begin
                wdt_err <= 1'b1;
            end
        end
    end
`else
    assign wdt_expired = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch : directed self-checking bench for instruction_fetch
// Rev 1.0 | watchdog scenario selected by INSTR_WATCHDOG_EN
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  instr_num = 8'd0;
    logic [7:0]  inst_mem_addr;
    logic [63:0] inst_mem_dout = 64'd0;
    logic [63:0] instruction;
    logic        CLP_enable;
    logic        CLP_done = 1'b0;
    logic        busy;
    logic        program_done;
    logic        timeout_err;

    logic [63:0] mem [0:255];
    logic [63:0] en_data [$];
    logic [7:0]  en_addr [$];
    int          done_cnt = 0;
    int          total = 0;
    int          bad = 0;

    instruction_fetch #(
        .ADDR_WIDTH (8),
        .WDT_LIMIT  (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .instr_num     (instr_num),
        .inst_mem_addr (inst_mem_addr),
        .inst_mem_dout (inst_mem_dout),
        .instruction   (instruction),
        .CLP_enable    (CLP_enable),
        .CLP_done      (CLP_done),
        .busy          (busy),
        .program_done  (program_done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) inst_mem_dout <= mem[inst_mem_addr];

    always @(negedge clk) begin
        if (CLP_enable === 1'b1) begin
            en_data.push_back(instruction);
            en_addr.push_back(inst_mem_addr);
        end
        if (program_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_enable(input string tag);
        int n = 0;
        while (CLP_enable !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(CLP_enable), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (program_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, 64'(program_done), 64'd1);
    endtask

    // Answers each CLP_enable with a CLP_done pulse dly cycles later.
    task automatic serve(input int n, input int dly, input string tag);
        for (int i = 0; i < n; i++) begin
            wait_enable(tag);
            repeat (dly) tick();
            CLP_done = 1'b1;
            tick();
            CLP_done = 1'b0;
        end
    endtask

    task automatic launch(input logic [7:0] num);
        en_data.delete();
        en_addr.delete();
        done_cnt  = 0;
        instr_num = num;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'hA + 64'(i);

        // reset state
        repeat (3) tick();
        check("rst_addr", 64'(inst_mem_addr), 64'd0);
        check("rst_instr", instruction, 64'd0);
        check("rst_enable", 64'(CLP_enable), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(program_done), 64'd0);
        check("rst_tmo", 64'(timeout_err), 64'd0);
        rst = 1'b0;
        tick();

        // three-instruction program with CLP_done 5 cycles after each enable
        launch(8'd3);
        check("a_busy", 64'(busy), 64'd1);
        check("a_fetch_addr", 64'(inst_mem_addr), 64'd0);
        check("a_lat_c1", 64'(CLP_enable), 64'd0);
        tick();
        check("a_lat_c2", 64'(CLP_enable), 64'd0);
        tick();
        check("a_lat_c3", 64'(CLP_enable), 64'd1);
        check("a_first_word", instruction, 64'hA);
        serve(3, 5, "a_enable");
        wait_done("a_done");
        tick();
        check("a_done_pulse", 64'(program_done), 64'd0);
        check("a_idle", 64'(busy), 64'd0);
        check("a_en_count", 64'(en_data.size()), 64'd3);
        check("a_done_count", 64'(done_cnt), 64'd1);
        if (en_data.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("a_word%0d", i), en_data[i], 64'hA + 64'(i));
                check($sformatf("a_addr%0d", i), 64'(en_addr[i]), 64'(i));
            end
        end

        // empty program
        launch(8'd0);
        check("z_done", 64'(program_done), 64'd1);
        check("z_busy", 64'(busy), 64'd1);
        check("z_enable", 64'(CLP_enable), 64'd0);
        tick();
        check("z_done_end", 64'(program_done), 64'd0);
        check("z_busy_end", 64'(busy), 64'd0);
        tick();
        check("z_en_count", 64'(en_data.size()), 64'd0);
        check("z_done_count", 64'(done_cnt), 64'd1);

        // start, instr_num change and CLP_done during ISSUE are ignored
        launch(8'd2);
        wait_enable("i_enable0");
        start     = 1'b1;
        CLP_done  = 1'b1;
        instr_num = 8'd0;
        tick();
        CLP_done  = 1'b0;
        check("i_exec_enable", 64'(CLP_enable), 64'd0);
        check("i_exec_busy", 64'(busy), 64'd1);
        check("i_exec_done", 64'(program_done), 64'd0);
        repeat (3) tick();
        check("i_still_exec", 64'(busy), 64'd1);
        check("i_still_pc", 64'(inst_mem_addr), 64'd0);
        start    = 1'b0;
        CLP_done = 1'b1;
        tick();
        CLP_done = 1'b0;
        serve(1, 5, "i_enable1");
        wait_done("i_done");
        repeat (3) tick();
        check("i_idle", 64'(busy), 64'd0);
        check("i_en_count", 64'(en_data.size()), 64'd2);
        check("i_done_count", 64'(done_cnt), 64'd1);
        if (en_data.size() == 2) begin
            check("i_word1", en_data[1], 64'hB);
            check("i_addr1", 64'(en_addr[1]), 64'd1);
        end

        // reset during EXEC of the second of four instructions
        launch(8'd4);
        serve(1, 2, "r_enable0");
        wait_enable("r_enable1");
        tick();
        check("r_exec_pc", 64'(inst_mem_addr), 64'd1);
        rst = 1'b1;
        tick();
        check("r_addr", 64'(inst_mem_addr), 64'd0);
        check("r_instr", instruction, 64'd0);
        check("r_enable", 64'(CLP_enable), 64'd0);
        check("r_busy", 64'(busy), 64'd0);
        check("r_done", 64'(program_done), 64'd0);
        rst = 1'b0;
        repeat (10) tick();
        check("r_no_done", 64'(done_cnt), 64'd0);
        check("r_no_enable", 64'(en_data.size()), 64'd2);
        launch(8'd2);
        serve(2, 1, "r2_enable");
        wait_done("r2_done");
        tick();
        check("r2_en_count", 64'(en_data.size()), 64'd2);
        if (en_data.size() == 2) begin
            check("r2_word0", en_data[0], 64'hA);
            check("r2_addr0", 64'(en_addr[0]), 64'd0);
            check("r2_word1", en_data[1], 64'hB);
        end

        // single instruction, CLP_done on the cycle EXEC is entered
        launch(8'd1);
        wait_enable("s_enable");
        tick();
        CLP_done = 1'b1;
        check("s_done_early", 64'(program_done), 64'd0);
        tick();
        CLP_done = 1'b0;
        check("s_done", 64'(program_done), 64'd1);
        tick();
        check("s_idle", 64'(busy), 64'd0);

`ifdef INSTR_WATCHDOG_EN
        // watchdog expiry 10 cycles after EXEC entry, flag stays sticky
        launch(8'd2);
        wait_enable("w_enable");
        tick();
        repeat (9) tick();
        check("w_done_early", 64'(program_done), 64'd0);
        check("w_tmo_early", 64'(timeout_err), 64'd0);
        tick();
        check("w_done", 64'(program_done), 64'd1);
        check("w_tmo", 64'(timeout_err), 64'd1);
        tick();
        launch(8'd0);
        tick();
        check("w_tmo_sticky", 64'(timeout_err), 64'd1);
        check("w_en_count", 64'(en_data.size()), 64'd0);
`else
        // without the watchdog EXEC waits indefinitely
        launch(8'd1);
        wait_enable("n_enable");
        repeat (30) tick();
        check("n_busy", 64'(busy), 64'd1);
        check("n_no_done", 64'(done_cnt), 64'd0);
        check("n_tmo", 64'(timeout_err), 64'd0);
        CLP_done = 1'b1;
        tick();
        CLP_done = 1'b0;
        check("n_done", 64'(program_done), 64'd1);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
